// File: rtl/wide_add_seq_pkg.sv
// Shared types and helpers for the multi-precision add/subtract sequencer.
package wide_add_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  // Byte-index width; never narrower than one bit so NBYTES=1 still has an index register.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/wide_add_seq_if.sv
// Request/response bundle between the sequencer and its client.
interface wide_add_seq_if #(parameter int NBYTES = 2);
  localparam int W = 8 * NBYTES;

  logic         i_start;
  logic         i_sub;
  logic         i_use_carry;
  logic [W-1:0] i_a;
  logic [W-1:0] i_b;
  logic         o_busy;
  logic         o_done;
  logic [W-1:0] o_y;
  logic         o_flag_c;
  logic         o_flag_v;
  logic         o_flag_z;
  logic         o_flag_n;

  modport slave (
    input  i_start, i_sub, i_use_carry, i_a, i_b,
    output o_busy, o_done, o_y, o_flag_c, o_flag_v, o_flag_z, o_flag_n
  );

  modport master (
    output i_start, i_sub, i_use_carry, i_a, i_b,
    input  o_busy, o_done, o_y, o_flag_c, o_flag_v, o_flag_z, o_flag_n
  );
endinterface

// File: rtl/wide_add_seq_adder8.sv
// Existing 8-bit ripple-carry adder with carry and signed-overflow outputs.
module wide_add_seq_adder8 (
  input  logic [7:0] i_a,
  input  logic [7:0] i_b,
  input  logic       i_ci,
  output logic [7:0] o_y,
  output logic       o_c,
  output logic       o_v
);
  logic [8:0] w_c;

  assign w_c[0] = i_ci;

  for (genvar g = 0; g < 8; g++) begin : g_bit
    assign o_y[g]   = i_a[g] ^ i_b[g] ^ w_c[g];
    assign w_c[g+1] = (i_a[g] & i_b[g]) | (w_c[g] & (i_a[g] ^ i_b[g]));
  end

  assign o_c = w_c[8];
  // Overflow: carry into the sign bit differs from carry out of it.
  assign o_v = w_c[8] ^ w_c[7];
endmodule

// File: rtl/wide_add_seq.sv
// Multi-precision add/subtract: streams NBYTES operands LSB-first through one 8-bit adder.
module wide_add_seq
  import wide_add_seq_pkg::*;
#(
  parameter int NBYTES = 2
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  wide_add_seq_if.slave  bus
);
  localparam int IW = idx_w(NBYTES);
  localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

  state_t                    r_state, w_state_nxt;
  logic [IW-1:0]             r_idx;
  logic [NBYTES-1:0][7:0]    r_opa;
  logic [NBYTES-1:0][7:0]    r_opb;
  logic [NBYTES-1:0][7:0]    r_res;
  logic                      r_carry;
  logic                      r_v;
  logic [NBYTES-1:0][7:0]    r_y;
  logic                      r_done;
  logic                      r_fc, r_fv, r_fz, r_fn;

  logic [7:0]                w_sum;
  logic                      w_co, w_vo;
  logic                      w_last;

  assign w_last = (r_idx == LAST);

  wide_add_seq_adder8 u_add (
    .i_a  (r_opa[r_idx]),
    .i_b  (r_opb[r_idx]),
    .i_ci (r_carry),
    .o_y  (w_sum),
    .o_c  (w_co),
    .o_v  (w_vo)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.i_start) w_state_nxt = S_RUN;
      S_RUN:   if (w_last)      w_state_nxt = S_FIN;
      S_FIN:                    w_state_nxt = S_IDLE;
      default:                  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_idx   <= '0;
      r_opa   <= '0;
      r_opb   <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_v     <= 1'b0;
      r_y     <= '0;
      r_done  <= 1'b0;
      r_fc    <= 1'b0;
      r_fv    <= 1'b0;
      r_fz    <= 1'b0;
      r_fn    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (bus.i_start) begin
          r_opa   <= bus.i_a;
          r_opb   <= bus.i_sub ? ~bus.i_b : bus.i_b;
          // ADC/SBC chain on the flag from the previous result; plain SUB needs +1.
          r_carry <= bus.i_use_carry ? r_fc : bus.i_sub;
          r_idx   <= '0;
        end
        S_RUN: begin
          r_res[r_idx] <= w_sum;
          r_carry      <= w_co;
          if (w_last) r_v   <= w_vo;
          else        r_idx <= r_idx + 1'b1;
        end
        S_FIN: begin
          r_done <= 1'b1;
          r_y    <= r_res;
          r_fc   <= r_carry;
          r_fv   <= r_v;
          r_fz   <= (r_res == '0);
          r_fn   <= r_res[NBYTES-1][7];
        end
        default: ;
      endcase
    end
  end

  assign bus.o_busy   = (r_state != S_IDLE);
  assign bus.o_done   = r_done;
  assign bus.o_y      = r_y;
  assign bus.o_flag_c = r_fc;
  assign bus.o_flag_v = r_fv;
  assign bus.o_flag_z = r_fz;
  assign bus.o_flag_n = r_fn;
endmodule

// File: tb/tb_wide_add_seq.sv
// Directed-vector bench for wide_add_seq at NBYTES=2.
module tb_wide_add_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  wide_add_seq_if #(.NBYTES(2)) bus ();

  wide_add_seq #(.NBYTES(2)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  // flags packed as {C,V,Z,N}
  function automatic logic [3:0] flags();
    return {bus.o_flag_c, bus.o_flag_v, bus.o_flag_z, bus.o_flag_n};
  endfunction

  task automatic run_op(input string tag, input logic sub, input logic uc,
                        input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] ey, input logic [3:0] ef);
    int   lat;
    logic busy_ok;
    @(negedge clk);
    bus.i_sub = sub; bus.i_use_carry = uc; bus.i_a = a; bus.i_b = b; bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
    lat = 0;
    busy_ok = 1'b1;
    while (!bus.o_done && lat < 12) begin
      if (!bus.o_busy) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    chk({tag, "_lat"},  lat, 3);
    chk({tag, "_busy"}, {31'd0, busy_ok}, 1);
    chk({tag, "_idle"}, {31'd0, bus.o_busy}, 0);
    chk({tag, "_y"},    {16'd0, bus.o_y}, {16'd0, ey});
    chk({tag, "_flg"},  {28'd0, flags()}, {28'd0, ef});
    @(negedge clk);
    chk({tag, "_pulse"}, {31'd0, bus.o_done}, 0);
  endtask

  logic [15:0] burst_a [10];
  logic [15:0] burst_b [10];
  logic [15:0] burst_exp [3];

  initial begin
    int ndone;
    bus.i_start = 1'b0; bus.i_sub = 1'b0; bus.i_use_carry = 1'b0;
    bus.i_a = '0; bus.i_b = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, bus.o_busy}, 0);
    chk("rst_done", {31'd0, bus.o_done}, 0);
    chk("rst_y",    {16'd0, bus.o_y}, 0);
    chk("rst_flg",  {28'd0, flags()}, 0);
    rst_n = 1'b1;

    run_op("add1",  1'b0, 1'b0, 16'h00FF, 16'h0001, 16'h0100, 4'b0000);
    run_op("addv",  1'b0, 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 4'b0101);
    run_op("subb",  1'b1, 1'b0, 16'h0000, 16'h0001, 16'hFFFF, 4'b0001);
    run_op("subz",  1'b1, 1'b0, 16'h1234, 16'h1234, 16'h0000, 4'b1010);
    run_op("addc",  1'b0, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 4'b1010);
    run_op("adc",   1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0001, 4'b0000);

    // START held every cycle: accepted only at i = 0, 4, 8
    for (int i = 0; i < 10; i++) begin
      burst_a[i] = 16'h0101 * i;
      burst_b[i] = 16'h00F0 + 16'(i);
    end
    burst_exp[0] = 16'h00F0;
    burst_exp[1] = 16'h04F8;
    burst_exp[2] = 16'h0900;
    ndone = 0;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      if (bus.o_done) begin
        if (ndone < 3) chk("burst_y", {16'd0, bus.o_y}, {16'd0, burst_exp[ndone]});
        ndone++;
      end
      if (i < 10) begin
        bus.i_sub = 1'b0; bus.i_use_carry = 1'b0;
        bus.i_a = burst_a[i]; bus.i_b = burst_b[i]; bus.i_start = 1'b1;
      end else begin
        bus.i_start = 1'b0;
      end
    end
    chk("burst_cnt", ndone, 3);

    // reset while the top byte is in flight
    @(negedge clk);
    bus.i_sub = 1'b0; bus.i_use_carry = 1'b0;
    bus.i_a = 16'h0102; bus.i_b = 16'h0304; bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
    @(negedge clk);
    chk("mid_busy_pre", {31'd0, bus.o_busy}, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_busy", {31'd0, bus.o_busy}, 0);
    chk("mid_done", {31'd0, bus.o_done}, 0);
    chk("mid_y",    {16'd0, bus.o_y}, 0);
    chk("mid_flg",  {28'd0, flags()}, 0);
    ndone = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.o_done) ndone++;
    end
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (bus.o_done) ndone++;
    end
    chk("mid_nodone", ndone, 0);
    run_op("post", 1'b0, 1'b0, 16'h0102, 16'h0304, 16'h0406, 4'b0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
